// File: rtl/cpu_sequencer.sv
// Multi-cycle sequencer for the MIPS231 datapath: fetches, performs load/store on a
// shared variable-latency memory port, then strobes a one-cycle commit enable.
module cpu_sequencer #(
  parameter int unsigned TIMEOUT = 32'd1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [31:0] pc,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] instr,
  output logic [31:0] ldata,
  output logic        enable,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ready,
  output logic        busy,
  output logic [31:0] retired,
  output logic        fault
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    MEM    = 3'd3,
    COMMIT = 3'd4,
    FAULT  = 3'd5
  } state_t;

  state_t      state;
  logic [31:0] wait_cnt;
  logic        timeout_hit;

  // A same-cycle m_ready always beats the watchdog.
  assign timeout_hit = (TIMEOUT != 32'd0) && (wait_cnt == TIMEOUT) && !m_ready;

  // Sequencer state, latched instruction/load data, retire counter and watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      instr    <= 32'd0;
      ldata    <= 32'd0;
      retired  <= 32'd0;
      wait_cnt <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (run) begin
            state    <= FETCH;
            wait_cnt <= 32'd0;
          end
        end
        FETCH: begin
          if (m_ready) begin
            instr <= m_rdata;
            state <= DECODE;
          end else if (timeout_hit) begin
            state <= FAULT;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        DECODE: begin
          if (is_load || is_store) begin
            state    <= MEM;
            wait_cnt <= 32'd0;
          end else begin
            state <= COMMIT;
          end
        end
        MEM: begin
          if (m_ready) begin
            if (is_load) begin
              ldata <= m_rdata;
            end
            state <= COMMIT;
          end else if (timeout_hit) begin
            state <= FAULT;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        COMMIT: begin
          retired <= retired + 32'd1;
          if (run) begin
            state    <= FETCH;
            wait_cnt <= 32'd0;
          end else begin
            state <= IDLE;
          end
        end
        FAULT: begin
          state <= FAULT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign m_req  = (state == FETCH) || (state == MEM);
  assign m_we   = (state == MEM) && is_store;
  assign enable = (state == COMMIT);
  assign busy   = (state != IDLE) && (state != FAULT);
  assign fault  = (state == FAULT);

  // Memory address/data mux; idle states present zeros to the bus.
  always_comb begin
    m_addr  = 32'd0;
    m_wdata = 32'd0;
    case (state)
      FETCH: begin
        m_addr  = pc;
        m_wdata = 32'd0;
      end
      MEM: begin
        m_addr  = d_addr;
        m_wdata = d_wdata;
      end
      default: begin
        m_addr  = 32'd0;
        m_wdata = 32'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: a memory responder with configurable wait states
// checks each completed transaction against a queue of expected transactions.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [31:0] pc;
  logic        is_load;
  logic        is_store;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] instr;
  logic [31:0] ldata;
  logic        enable;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ready;
  logic        busy;
  logic [31:0] retired;
  logic        fault;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   fetch_wait = 0;
  int   mem_wait   = 0;
  bit   never_ready = 1'b0;

  cpu_sequencer #(.TIMEOUT(32'd4)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .pc(pc),
    .is_load(is_load), .is_store(is_store), .d_addr(d_addr), .d_wdata(d_wdata),
    .instr(instr), .ldata(ldata), .enable(enable),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready),
    .busy(busy), .retired(retired), .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a == 32'h0000_0040) ? 32'hDEAD_BEEF : (a ^ 32'hA5A5_0000);
  endfunction

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push(input logic we, input logic [31:0] a, input logic [31:0] wd);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = wd;
    exp_q.push_back(t);
  endtask

  // Memory model: answers requests after the configured wait, advances pc on commit.
  initial begin
    int   cnt;
    int   lim;
    txn_t t;
    cnt = 0;
    m_ready = 1'b0;
    m_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (m_req && rst_n) begin
        lim = (m_addr == pc) ? fetch_wait : mem_wait;
        if (!never_ready && cnt >= lim) begin
          m_ready = 1'b1;
          m_rdata = m_we ? 32'd0 : mem_data(m_addr);
          cnt = 0;
          if (exp_q.size() == 0) begin
            check("unexpected_txn", {m_we, m_addr, m_wdata}, 192'd0);
          end else begin
            t = exp_q.pop_front();
            check("txn", {m_we, m_addr, m_wdata}, {t.we, t.addr, t.wdata});
          end
        end else begin
          m_ready = 1'b0;
          cnt++;
        end
      end else begin
        m_ready = 1'b0;
        cnt = 0;
      end
      if (enable) pc = pc + 32'd4;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [8:0] enmask;
    int         cnt_a;
    int         cnt_b;
    logic       flag;
    rst_n = 1'b0; run = 1'b0; pc = 32'h0000_0100;
    is_load = 1'b0; is_store = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
    step(); step();
    check("reset_outputs",
          {instr, ldata, retired, fault, enable, m_req, m_we, m_addr, m_wdata, busy}, 192'd0);
    rst_n = 1'b1;
    step();

    // ALU stream: three zero-wait non-memory instructions
    push(1'b0, 32'h100, 32'd0); push(1'b0, 32'h104, 32'd0); push(1'b0, 32'h108, 32'd0);
    run = 1'b1; enmask = 9'd0; flag = 1'b0;
    step();
    for (int c = 1; c <= 9; c++) begin
      if (c > 1) step();
      if (enable) enmask[c-1] = 1'b1;
      if (m_we) flag = 1'b1;
      if (c == 9) run = 1'b0;
    end
    step();
    check("alu_enable_cycles", enmask, 9'b100100100);
    check("alu_retired", retired, 32'd3);
    check("alu_no_write", flag, 1'b0);
    check("alu_instr", instr, 32'h0000_0108 ^ 32'hA5A5_0000);

    // Load with two memory wait states
    is_load = 1'b1; d_addr = 32'h40; d_wdata = 32'd0; mem_wait = 2;
    push(1'b0, 32'h10C, 32'd0); push(1'b0, 32'h40, 32'd0);
    run = 1'b1; enmask = 9'd0; cnt_a = 0;
    step();
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) step();
      if (m_req && m_addr == 32'h40) cnt_a++;
      if (enable) begin
        enmask[c-1] = 1'b1;
        check("load_ldata_at_commit", ldata, 32'hDEAD_BEEF);
      end
      if (c == 6) run = 1'b0;
    end
    step();
    check("load_mem_cycles", cnt_a, 3);
    check("load_enable_cycle", enmask, 9'b000100000);
    check("load_retired", retired, 32'd4);
    is_load = 1'b0; mem_wait = 0;

    // Store: one write transaction, one commit
    is_store = 1'b1; d_addr = 32'h80; d_wdata = 32'h1234;
    push(1'b0, 32'h110, 32'd0); push(1'b1, 32'h80, 32'h1234);
    run = 1'b1; cnt_a = 0; cnt_b = 0;
    step();
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) step();
      if (m_req && m_we) cnt_a++;
      if (enable) cnt_b++;
      if (c == 4) run = 1'b0;
    end
    step();
    check("store_write_cycles", cnt_a, 1);
    check("store_enable_count", cnt_b, 1);
    check("store_keeps_ldata", ldata, 32'hDEAD_BEEF);
    check("store_retired", retired, 32'd5);
    is_store = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;

    // run dropped during DECODE: the instruction still commits
    push(1'b0, 32'h114, 32'd0);
    run = 1'b1;
    step();
    step();
    run = 1'b0;
    step();
    check("drop_run_commit", {enable, busy}, 2'b11);
    step();
    check("drop_run_idle", {busy, m_req, enable}, 3'b000);
    check("drop_run_retired", retired, 32'd6);

    // Ready arrives on the 5th fetch cycle with TIMEOUT=4
    fetch_wait = 4;
    push(1'b0, 32'h118, 32'd0);
    run = 1'b1; enmask = 9'd0; flag = 1'b0;
    step();
    for (int c = 1; c <= 7; c++) begin
      if (c > 1) step();
      if (enable) enmask[c-1] = 1'b1;
      if (fault) flag = 1'b1;
      if (c == 7) run = 1'b0;
    end
    step();
    check("ready_at_timeout_no_fault", flag, 1'b0);
    check("ready_at_timeout_enable", enmask, 9'b001000000);
    check("ready_at_timeout_retired", retired, 32'd7);
    fetch_wait = 0;

    // Retire counter wrap
    force dut.retired = 32'hFFFF_FFFF;
    step();
    release dut.retired;
    step();
    check("retired_preload", retired, 32'hFFFF_FFFF);
    push(1'b0, 32'h11C, 32'd0);
    run = 1'b1;
    step(); step(); step();
    run = 1'b0;
    step();
    check("retired_wrap", retired, 32'd0);

    // Asynchronous reset in the middle of a store's MEM phase
    is_store = 1'b1; d_addr = 32'h80; d_wdata = 32'h1234; mem_wait = 3;
    push(1'b0, 32'h120, 32'd0);
    run = 1'b1;
    step(); step(); step();
    check("mid_store_strobes", {m_req, m_we, m_addr}, {1'b1, 1'b1, 32'h80});
    #2 rst_n = 1'b0;
    #1;
    check("reset_mid_store",
          {instr, ldata, retired, fault, enable, m_req, m_we, m_addr, m_wdata, busy}, 192'd0);
    run = 1'b0;
    step();
    rst_n = 1'b1;
    is_store = 1'b0; d_addr = 32'd0; d_wdata = 32'd0; mem_wait = 0;
    step();

    // Fetch never completes: watchdog faults after five request cycles
    never_ready = 1'b1;
    run = 1'b1; cnt_a = 0;
    step();
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) step();
      if (m_req) cnt_a++;
      if (c == 1) run = 1'b0;
    end
    check("timeout_req_cycles", cnt_a, 5);
    check("timeout_fault_state", {fault, busy, m_req}, 3'b100);
    step(); step(); step();
    check("timeout_sticky", {fault, busy, m_req, enable}, 4'b1000);
    never_ready = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check("timeout_cleared_by_reset", {fault, busy}, 2'b00);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
